// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch/countdown digit chains:
// FSM states, 7-segment patterns (active-high, bit0 = a) and BCD limits.
package cronometro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_MAX_UNIT = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/bcd_para_7seg.sv
// Combinational BCD to 7-segment decoder, shared with the up-counting chain.
// Non-BCD codes decode to blank.
module bcd_para_7seg
    import cronometro_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/contador_regressivo.sv
// MM:SS BCD countdown timer: load/clamp, start/pause FSM, BCD borrow chain
// and alarm at 00:00, with four 7-segment digit outputs.
module contador_regressivo
    import cronometro_pkg::*;
#(
    parameter int MAX_MIN_TENS = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       LOAD,
    input  logic [3:0] SET_MT,
    input  logic [3:0] SET_MU,
    input  logic [3:0] SET_ST,
    input  logic [3:0] SET_SU,
    input  logic       START,
    output logic [6:0] SEG_MT,
    output logic [6:0] SEG_MU,
    output logic [6:0] SEG_ST,
    output logic [6:0] SEG_SU,
    output logic       RUNNING,
    output logic       ALARM
);

    localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

    // Digit index: 3 = min tens, 2 = min units, 1 = sec tens, 0 = sec units.
    logic [3:0][3:0] dig_q, dig_d, dig_load, dig_dec;
    logic [3:0][6:0] seg;
    estado_t         estado_q, estado_d;
    logic            is_zero, dec_zero;

    always_comb begin
        dig_load[3] = (SET_MT > MT_MAX)       ? MT_MAX       : SET_MT;
        dig_load[2] = (SET_MU > BCD_MAX_UNIT) ? BCD_MAX_UNIT : SET_MU;
        dig_load[1] = (SET_ST > BCD_MAX_TENS) ? BCD_MAX_TENS : SET_ST;
        dig_load[0] = (SET_SU > BCD_MAX_UNIT) ? BCD_MAX_UNIT : SET_SU;
    end

    // Borrow ripples from sec units upward; only used when the value is nonzero.
    always_comb begin
        dig_dec = dig_q;
        if (dig_q[0] != 4'd0) begin
            dig_dec[0] = dig_q[0] - 4'd1;
        end else begin
            dig_dec[0] = BCD_MAX_UNIT;
            if (dig_q[1] != 4'd0) begin
                dig_dec[1] = dig_q[1] - 4'd1;
            end else begin
                dig_dec[1] = BCD_MAX_TENS;
                if (dig_q[2] != 4'd0) begin
                    dig_dec[2] = dig_q[2] - 4'd1;
                end else begin
                    dig_dec[2] = BCD_MAX_UNIT;
                    dig_dec[3] = dig_q[3] - 4'd1;
                end
            end
        end
    end

    assign is_zero  = (dig_q == '0);
    assign dec_zero = (dig_dec == '0);

    always_comb begin
        dig_d    = dig_q;
        estado_d = estado_q;
        if (LOAD) begin
            dig_d    = dig_load;
            estado_d = ST_IDLE;
        end else begin
            case (estado_q)
                ST_IDLE:  if (START && !is_zero) estado_d = ST_RUN;
                ST_RUN: begin
                    if (START) begin
                        estado_d = ST_PAUSE;
                    end else if (TICK && !is_zero) begin
                        dig_d = dig_dec;
                        if (dec_zero) estado_d = ST_DONE;
                    end
                end
                ST_PAUSE: if (START) estado_d = ST_RUN;
                ST_DONE:  if (START) estado_d = ST_IDLE;
                default:  estado_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dig_q    <= '0;
            estado_q <= ST_IDLE;
        end else begin
            dig_q    <= dig_d;
            estado_q <= estado_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_dec
        bcd_para_7seg u_dec (
            .bcd (dig_q[i]),
            .seg (seg[i])
        );
    end

    assign SEG_MT  = seg[3];
    assign SEG_MU  = seg[2];
    assign SEG_ST  = seg[1];
    assign SEG_SU  = seg[0];
    assign RUNNING = (estado_q == ST_RUN);
    assign ALARM   = (estado_q == ST_DONE);

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed vector bench for contador_regressivo: table of pulses/presets with
// expected digits and flags, plus reset and clamp-parameter sequences.
module tb_contador_regressivo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       TICK = 1'b0, LOAD = 1'b0, START = 1'b0;
    logic [3:0] SET_MT = '0, SET_MU = '0, SET_ST = '0, SET_SU = '0;
    logic [6:0] SEG_MT, SEG_MU, SEG_ST, SEG_SU;
    logic       RUNNING, ALARM;
    logic [6:0] SEG2_MT, SEG2_MU, SEG2_ST, SEG2_SU;
    logic       RUNNING2, ALARM2;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    contador_regressivo dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .LOAD(LOAD),
        .SET_MT(SET_MT), .SET_MU(SET_MU), .SET_ST(SET_ST), .SET_SU(SET_SU),
        .START(START),
        .SEG_MT(SEG_MT), .SEG_MU(SEG_MU), .SEG_ST(SEG_ST), .SEG_SU(SEG_SU),
        .RUNNING(RUNNING), .ALARM(ALARM)
    );

    contador_regressivo #(.MAX_MIN_TENS(3)) dut3 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .LOAD(LOAD),
        .SET_MT(SET_MT), .SET_MU(SET_MU), .SET_ST(SET_ST), .SET_SU(SET_SU),
        .START(START),
        .SEG_MT(SEG2_MT), .SEG_MU(SEG2_MU), .SEG_ST(SEG2_ST), .SEG_SU(SEG2_SU),
        .RUNNING(RUNNING2), .ALARM(ALARM2)
    );

    typedef struct {
        logic       ld, st, tk;
        logic [3:0] smt, smu, sst, ssu;
        logic [3:0] emt, emu, est, esu;
        logic       erun, ealm;
    } vec_t;

    vec_t vt[$];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;
            4'd2: return 7'h5B;  4'd3: return 7'h4F;
            4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;
            4'd8: return 7'h7F;  4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic add(input logic ld, st, tk, input logic [15:0] set,
                       input logic [15:0] exp, input logic erun, ealm);
        vec_t v;
        v.ld = ld; v.st = st; v.tk = tk;
        v.smt = set[15:12]; v.smu = set[11:8]; v.sst = set[7:4]; v.ssu = set[3:0];
        v.emt = exp[15:12]; v.emu = exp[11:8]; v.est = exp[7:4]; v.esu = exp[3:0];
        v.erun = erun; v.ealm = ealm;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] exp,
                         input logic erun, ealm);
        logic [27:0] got, want;
        got  = {SEG_MT, SEG_MU, SEG_ST, SEG_SU};
        want = {seg_of(exp[15:12]), seg_of(exp[11:8]), seg_of(exp[7:4]), seg_of(exp[3:0])};
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s segs got %h expected %h (digits %h)", name, got, want, exp);
        end
        if (RUNNING !== erun || ALARM !== ealm) begin
            nerr++;
            $display("FAIL %s run/alarm got %b%b expected %b%b", name, RUNNING, ALARM, erun, ealm);
        end
    endtask

    task automatic step(input logic ld, st, tk, input logic [15:0] set);
        @(negedge CLK);
        LOAD = ld; START = st; TICK = tk;
        {SET_MT, SET_MU, SET_ST, SET_SU} = set;
        @(posedge CLK);
        #1;
        LOAD = 0; START = 0; TICK = 0;
    endtask

    initial begin
        // ld st tk  preset     expected  run alm
        add(0,0,1, 16'h0000, 16'h0000, 0,0);
        add(0,0,1, 16'h0000, 16'h0000, 0,0);
        add(0,0,1, 16'h0000, 16'h0000, 0,0);
        add(1,0,0, 16'h1000, 16'h1000, 0,0);
        add(0,1,0, 16'h0000, 16'h1000, 1,0);
        add(0,0,1, 16'h0000, 16'h0959, 1,0);
        add(0,0,1, 16'h0000, 16'h0958, 1,0);
        add(1,0,0, 16'h0002, 16'h0002, 0,0);
        add(0,1,0, 16'h0000, 16'h0002, 1,0);
        add(0,0,1, 16'h0000, 16'h0001, 1,0);
        add(0,0,1, 16'h0000, 16'h0000, 0,1);
        add(0,0,1, 16'h0000, 16'h0000, 0,1);
        add(0,0,1, 16'h0000, 16'h0000, 0,1);
        add(0,1,0, 16'h0000, 16'h0000, 0,0);
        add(1,0,0, 16'h0030, 16'h0030, 0,0);
        add(0,1,0, 16'h0000, 16'h0030, 1,0);
        add(0,0,1, 16'h0000, 16'h0029, 1,0);
        add(0,1,1, 16'h0000, 16'h0029, 0,0);
        for (int i = 0; i < 5; i++) add(0,0,1, 16'h0000, 16'h0029, 0,0);
        add(0,1,0, 16'h0000, 16'h0029, 1,0);
        add(0,0,1, 16'h0000, 16'h0028, 1,0);
        add(1,1,1, 16'hFC7A, 16'h9959, 0,0);
        add(1,0,0, 16'h0000, 16'h0000, 0,0);
        add(0,1,0, 16'h0000, 16'h0000, 0,0);
        add(1,0,0, 16'h0100, 16'h0100, 0,0);
        add(0,1,0, 16'h0000, 16'h0100, 1,0);
        add(0,0,1, 16'h0000, 16'h0059, 1,0);
        add(1,0,0, 16'h0010, 16'h0010, 0,0);
        add(0,1,0, 16'h0000, 16'h0010, 1,0);
        add(0,0,1, 16'h0000, 16'h0009, 1,0);
        add(1,0,0, 16'h0001, 16'h0001, 0,0);
        add(0,1,0, 16'h0000, 16'h0001, 1,0);
        add(0,0,1, 16'h0000, 16'h0000, 0,1);
        add(1,0,0, 16'h0500, 16'h0500, 0,0);
        add(0,0,1, 16'h0000, 16'h0500, 0,0);

        #2;
        check("reset_hold", 16'h0000, 0, 0);
        @(negedge CLK);
        RST = 1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].ld, vt[i].st, vt[i].tk, {vt[i].smt, vt[i].smu, vt[i].sst, vt[i].ssu});
            check($sformatf("vec%0d", i), {vt[i].emt, vt[i].emu, vt[i].est, vt[i].esu},
                  vt[i].erun, vt[i].ealm);
        end

        // Clamp against a smaller tens-of-minutes limit on the second instance
        step(1, 0, 0, 16'hFC7A);
        nvec++;
        if ({SEG2_MT, SEG2_MU, SEG2_ST, SEG2_SU} !== {7'h4F, 7'h6F, 7'h6D, 7'h6F}) begin
            nerr++;
            $display("FAIL clamp_max3 got %h expected %h",
                     {SEG2_MT, SEG2_MU, SEG2_ST, SEG2_SU}, {7'h4F, 7'h6F, 7'h6D, 7'h6F});
        end

        // Asynchronous reset mid-cycle while running at 12:34
        step(1, 0, 0, 16'h1234);
        step(0, 1, 0, 16'h0000);
        check("pre_async", 16'h1234, 1, 0);
        #2;
        RST = 0;
        #1;
        check("async_reset", 16'h0000, 0, 0);
        @(negedge CLK);
        RST = 1;
        step(0, 0, 1, 16'h0000);
        check("post_reset_tick", 16'h0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
